// File: rtl/mod_n_counter.sv
// Modulo-N up/down counter with enable, synchronous clamped load, Mealy and
// registered terminal-count flags, and a saturating count of terminal events.
module mod_n_counter #(
  parameter int unsigned WIDTH    = 4,
  parameter int unsigned MODULUS  = 16,
  parameter int unsigned SATURATE = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             x,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q,
  output logic             z,
  output logic             zq,
  output logic [7:0]       wrap_cnt
);

  localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

  logic [WIDTH-1:0] term;
  logic [WIDTH-1:0] q_nxt;
  logic             at_term;

  always_comb begin
    term    = up ? MAXV : '0;
    at_term = (q == term);
    z       = x & ~load & at_term;
    q_nxt   = q;
    if (load) begin
      // Out-of-range load values clamp to the top of the range
      q_nxt = (d > MAXV) ? MAXV : d;
    end else if (x) begin
      if (!at_term) begin
        q_nxt = up ? q + WIDTH'(1) : q - WIDTH'(1);
      end else if (SATURATE == 0) begin
        q_nxt = up ? '0 : MAXV;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q        <= '0;
      zq       <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      q  <= q_nxt;
      zq <= z;
      if (z && (wrap_cnt != 8'hFF)) begin
        wrap_cnt <= wrap_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_mod_n_counter.sv
// Bench for mod_n_counter: three configurations share one stimulus stream and
// are compared against an arithmetic reference model, plus directed vectors.
module tb_mod_n_counter;

  logic       clk;
  logic       rst_n;
  logic       x;
  logic       up;
  logic       load;
  logic [3:0] d;

  logic [3:0] q0, q1;
  logic [1:0] q2;
  logic       z0, z1, z2;
  logic       zq0, zq1, zq2;
  logic [7:0] w0, w1, w2;

  mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(0)) dut (
    .clk(clk), .rst_n(rst_n), .x(x), .up(up), .load(load), .d(d),
    .q(q0), .z(z0), .zq(zq0), .wrap_cnt(w0)
  );

  mod_n_counter #(.WIDTH(4), .MODULUS(10), .SATURATE(1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .x(x), .up(up), .load(load), .d(d),
    .q(q1), .z(z1), .zq(zq1), .wrap_cnt(w1)
  );

  mod_n_counter #(.WIDTH(2), .MODULUS(4), .SATURATE(0)) dut_w2 (
    .clk(clk), .rst_n(rst_n), .x(x), .up(up), .load(load), .d(d[1:0]),
    .q(q2), .z(z2), .zq(zq2), .wrap_cnt(w2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: per-instance configuration and state
  int mm[3] = '{10, 10, 4};
  int ms[3] = '{0, 1, 0};
  int mwd[3] = '{4, 4, 2};
  int mq[3];
  int mzq[3];
  int mw[3];

  typedef struct {
    bit x;
    bit up;
    bit load;
    int d;
    bit ez;
    int eq;
    int ew;
  } vec_t;
  vec_t tbl[12];

  task automatic chk(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int get_q(input int i);
    case (i)
      0: return int'(q0);
      1: return int'(q1);
      default: return int'(q2);
    endcase
  endfunction

  function automatic int get_z(input int i);
    case (i)
      0: return int'(z0);
      1: return int'(z1);
      default: return int'(z2);
    endcase
  endfunction

  function automatic int get_zq(input int i);
    case (i)
      0: return int'(zq0);
      1: return int'(zq1);
      default: return int'(zq2);
    endcase
  endfunction

  function automatic int get_w(input int i);
    case (i)
      0: return int'(w0);
      1: return int'(w1);
      default: return int'(w2);
    endcase
  endfunction

  function automatic int model_z(input int i);
    int t;
    t = up ? mm[i] - 1 : 0;
    return (x && !load && mq[i] == t) ? 1 : 0;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      mq[i] = 0; mzq[i] = 0; mw[i] = 0;
    end
  endtask

  // One clock: check z before the edge, advance the model on the edge,
  // check registered outputs on the following falling edge.
  task automatic cycle();
    int ez[3];
    int dv;
    int t;
    for (int i = 0; i < 3; i++) begin
      ez[i] = model_z(i);
      chk($sformatf("z[%0d]", i), get_z(i), ez[i]);
    end
    @(posedge clk);
    for (int i = 0; i < 3; i++) begin
      t = up ? mm[i] - 1 : 0;
      if (load) begin
        dv = int'(d) % (1 << mwd[i]);
        mq[i] = (dv > mm[i] - 1) ? mm[i] - 1 : dv;
      end else if (x && !(ms[i] == 1 && mq[i] == t)) begin
        mq[i] = up ? (mq[i] + 1) % mm[i] : (mq[i] + mm[i] - 1) % mm[i];
      end
      mzq[i] = ez[i];
      if (ez[i] == 1 && mw[i] < 255) mw[i] = mw[i] + 1;
    end
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("q[%0d]", i), get_q(i), mq[i]);
      chk($sformatf("zq[%0d]", i), get_zq(i), mzq[i]);
      chk($sformatf("wrap_cnt[%0d]", i), get_w(i), mw[i]);
    end
  endtask

  task automatic check_reset_state(input string tag);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("%s q[%0d]", tag, i), get_q(i), 0);
      chk($sformatf("%s zq[%0d]", tag, i), get_zq(i), 0);
      chk($sformatf("%s wrap_cnt[%0d]", tag, i), get_w(i), 0);
    end
  endtask

  int seq2[6] = '{1, 2, 3, 0, 1, 2};

  initial begin
    tbl[0]  = '{1, 1, 0, 0,  0, 1, 0};
    tbl[1]  = '{1, 1, 0, 0,  0, 2, 0};
    tbl[2]  = '{0, 1, 0, 0,  0, 2, 0};
    tbl[3]  = '{0, 1, 1, 13, 0, 9, 0};
    tbl[4]  = '{1, 1, 0, 0,  1, 0, 1};
    tbl[5]  = '{1, 0, 0, 0,  1, 9, 2};
    tbl[6]  = '{1, 1, 1, 2,  0, 2, 2};
    tbl[7]  = '{1, 0, 0, 0,  0, 1, 2};
    tbl[8]  = '{0, 0, 0, 0,  0, 1, 2};
    tbl[9]  = '{0, 0, 1, 15, 0, 9, 2};
    tbl[10] = '{0, 1, 0, 0,  0, 9, 2};
    tbl[11] = '{1, 1, 1, 9,  0, 9, 2};

    // Reset state and combinational z during reset
    rst_n = 1'b0; x = 1'b1; up = 1'b0; load = 1'b0; d = '0;
    model_reset();
    #12;
    check_reset_state("reset");
    chk("reset z down-terminal", int'(z0), 1);
    up = 1'b1;
    #1;
    chk("reset z up", int'(z0), 0);
    x = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;

    // Directed vectors on the MODULUS=10 wrapping instance
    for (int k = 0; k < 12; k++) begin
      x = tbl[k].x; up = tbl[k].up; load = tbl[k].load; d = 4'(tbl[k].d);
      #1;
      chk($sformatf("vec%0d z", k), int'(z0), int'(tbl[k].ez));
      cycle();
      chk($sformatf("vec%0d q", k), int'(q0), tbl[k].eq);
      chk($sformatf("vec%0d wrap", k), int'(w0), tbl[k].ew);
    end

    // Randomized stimulus against the model
    for (int k = 0; k < 400; k++) begin
      x    = ($urandom_range(0, 3) != 0);
      up   = ($urandom_range(0, 7) < 5);
      load = ($urandom_range(0, 9) == 0);
      d    = 4'($urandom_range(0, 15));
      #1;
      cycle();
    end

    // Asynchronous reset between edges
    x = 1'b1; up = 1'b1; load = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_reset_state("midreset");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Two-bit modulo-4 up count: 0,1,2,3,0,1,...
    x = 1'b1; up = 1'b1; load = 1'b0; d = '0;
    for (int k = 0; k < 6; k++) begin
      #1;
      cycle();
      chk($sformatf("w2 seq%0d", k), int'(q2), seq2[k]);
    end
    chk("w2 wrap after first wrap", int'(w2), 1);

    // Saturating instance: climbs to 9 then sticks with z held high
    for (int k = 0; k < 9; k++) begin
      #1;
      cycle();
    end
    chk("sat q sticks", int'(q1), 9);
    chk("sat z held", int'(z1), 1);
    chk("sat wrap after 6", int'(w1), 6);
    for (int k = 0; k < 260; k++) begin
      #1;
      cycle();
    end
    chk("sat wrap_cnt saturates", int'(w1), 255);
    chk("sat q still 9", int'(q1), 9);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
